// File: rtl/shift_reg_pkg.sv
// Shared constants for the PISO shift register: FSM state encodings and default word width.
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/shift_register_piso_bit_counter.sv
// Bit-position counter with enable, synchronous clear and a terminal-count flag.
module bit_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shift register with load handshake and stallable output.
// Define SHIFT_REG_PARITY_EN to append an even-parity bit after each word.
module shift_register_piso
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_q;
  logic             msb_q;
  logic             last_bit;
  logic             accept;
  logic             advance;
  logic             next_bit;
`ifdef SHIFT_REG_PARITY_EN
  logic             parity_q;
`endif

  assign load_ready = (state == ST_IDLE);
  assign accept     = load_valid && load_ready;
  assign advance    = shift_en && (state == ST_SHIFT);
  assign next_bit   = msb_q ? shift_q[WIDTH-1] : shift_q[0];

  // Counter holds the index of the bit currently on ser_out
  bit_counter #(
    .WIDTH    (CW),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept || (advance && last_bit)),
    .enable   (advance && !last_bit),
    .terminal (last_bit)
  );

`ifdef SHIFT_REG_PARITY_EN
  assign done = (state == ST_PARITY);
`else
  assign done = (state == ST_SHIFT) && last_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      msb_q     <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state     <= ST_SHIFT;
            msb_q     <= msb_first;
            ser_valid <= 1'b1;
            // First bit goes straight to ser_out; the register keeps the rest
            ser_out   <= msb_first ? load_data[WIDTH-1] : load_data[0];
            shift_q   <= msb_first ? {load_data[WIDTH-2:0], 1'b0}
                                   : {1'b0, load_data[WIDTH-1:1]};
`ifdef SHIFT_REG_PARITY_EN
            parity_q  <= ^load_data;
`endif
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (last_bit) begin
`ifdef SHIFT_REG_PARITY_EN
              state     <= ST_PARITY;
              ser_out   <= parity_q;
`else
              state     <= ST_IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
`endif
            end else begin
              ser_out <= next_bit;
              shift_q <= msb_q ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};
            end
          end
        end
`ifdef SHIFT_REG_PARITY_EN
        ST_PARITY: begin
          if (shift_en) begin
            state     <= ST_IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_register_piso.md
SHIFT_REGISTER_PISO -- requirements
Module: shift_register_piso

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per parallel load; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  parallel word offered.
REQ-005 load_ready  output  1  block can accept a word; high only in IDLE.
REQ-006 load_data  input  WIDTH  parallel word, captured on accepted load.
REQ-007 msb_first  input  1  bit order, captured with the load: 1 = MSB first, 0 = LSB first.
REQ-008 shift_en  input  1  shift advance enable; 0 stalls serial output.
REQ-009 ser_out  output  1  current serial bit, registered.
REQ-010 ser_valid  output  1  ser_out carries a valid bit.
REQ-011 done  output  1  one-cycle pulse marking the final serial bit of a word.

Function
REQ-012 The load SHALL be accepted at a rising edge where load_valid=1 and load_ready=1; load_data and msb_first are captured into internal registers.
REQ-013 The FSM SHALL have states IDLE, SHIFT and (with parity) PARITY; IDLE->SHIFT on accepted load; SHIFT->IDLE or PARITY after WIDTH presented bits; PARITY->IDLE after one presented bit.
REQ-014 Latency: the first bit SHALL appear on ser_out with ser_valid=1 in the cycle after the accepting edge.
REQ-015 Each bit SHALL remain on ser_out until a rising edge with shift_en=1; that edge advances to the next bit; a bit counter of ceil(log2(WIDTH+1)) bits tracks progress.
REQ-016 shift_en=0 SHALL hold ser_out, ser_valid, the counter and the state unchanged; a stall is unlimited in length.
REQ-017 done SHALL be 1 exactly while the last bit of the word is presented (bit WIDTH-1 without parity, the parity bit with parity) and 0 otherwise.
REQ-018 After the final bit is advanced by shift_en=1, the block SHALL return to IDLE with ser_valid=0, ser_out=0, load_ready=1 in the following cycle.
REQ-019 load_valid while load_ready=0 SHALL be ignored; no data is captured and the current word is not disturbed.
REQ-020 Changes on msb_first or load_data after acceptance SHALL have no effect on the word in flight.
REQ-021 In IDLE, ser_out=0, ser_valid=0, done=0.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, counter=0, ser_out=0, ser_valid=0, done=0, load_ready=1, and SHALL take priority over load, shift_en and any in-progress word.
REQ-023 A reset mid-word SHALL discard the remaining bits; no done pulse is produced for the aborted word.

Configuration
REQ-024 With macro SHIFT_REG_PARITY_EN defined, the block SHALL append one even-parity bit (XOR of the captured word) after the WIDTH data bits, in state PARITY, making a word WIDTH+1 presented bits.
REQ-025 Without SHIFT_REG_PARITY_EN, the PARITY state and parity logic SHALL be absent and a word is exactly WIDTH presented bits.

Structure
REQ-026 FSM state encodings (IDLE, SHIFT, PARITY) and the default WIDTH constant SHALL reside in shared package shift_reg_pkg.
REQ-027 The bit counter with enable, synchronous clear and terminal-count output SHALL be a separate sub-module named bit_counter.

Verification
REQ-028 WIDTH=8, load 8'h1E msb_first=1, shift_en=1 -> ser_out 0,0,0,1,1,1,1,0 on cycles 1-8, done only on cycle 8, load_ready=1 on cycle 9.
REQ-029 Load 8'h1E msb_first=0 -> ser_out 0,1,1,1,1,0,0,0; done on cycle 8.
REQ-030 Load 8'h1E msb_first=1, shift_en=0 for 3 cycles after bit 3 -> bit 3 held 4 cycles, done on cycle 11, sequence unchanged.
REQ-031 rst=1 while bit 4 presented -> next cycle ser_valid=0, ser_out=0, done=0, load_ready=1; new load 8'hFF then shifts 1 x8 normally.
REQ-032 load_valid=1 with 8'h00 during a word in flight -> ignored; in-flight word output unchanged.
REQ-033 SHIFT_REG_PARITY_EN defined, load 8'h07 msb_first=1 -> ser_out 0,0,0,0,0,1,1,1,1 on cycles 1-9, done only on cycle 9.
